// File: rtl/ebus_arb.sv
// EBUS master arbiter: round-robin grant, one-cycle settle, demand with
// timeout, hold until the winner releases. Every output is a flop.
module ebus_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TMO  = 255
) (
    input  logic            masterClk,
    input  logic            CROBAR_N,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    input  logic            xfer,
    output logic [NREQ-1:0] grant,
    output logic            demand,
    output logic            xferOk,
    output logic            timeout,
    output logic            busy
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = $clog2(TMO + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TMO - 1);
    localparam logic [PtrW-1:0] PtrInit = PtrW'(NREQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StDemand,
        StHold,
        StRecover
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            demand_q, demand_d;
    logic            xferok_q, xferok_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;

    logic            any_req;
    logic [PtrW-1:0] win_idx;
    logic [PtrW-1:0] cand;
    logic [NREQ-1:0] win_oh;
    logic            granted_done;

    // ptr_q holds the current winner while a transaction is open.
    assign granted_done = done[ptr_q];

    // Round-robin search starting just after the previous winner.
    always_comb begin
        any_req = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = PtrW'((int'(ptr_q) + k) % int'(NREQ));
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    // State register and registered outputs.
    always_ff @(posedge masterClk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state_q   <= StIdle;
            ptr_q     <= PtrInit;
            cnt_q     <= '0;
            grant_q   <= '0;
            demand_q  <= 1'b0;
            xferok_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            demand_q  <= demand_d;
            xferok_q  <= xferok_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; a release by the winner outranks xfer and timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) state_d = StSetup;
            end
            StSetup: begin
                state_d = granted_done ? StIdle : StDemand;
            end
            StDemand: begin
                if (granted_done)          state_d = StIdle;
                else if (xfer)             state_d = StHold;
                else if (cnt_q == CntLast) state_d = StRecover;
            end
            StHold: begin
                if (granted_done && !xfer) state_d = StIdle;
            end
            StRecover: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next values, derived from the transition being taken.
    always_comb begin
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = '0;
        demand_d  = (state_d == StDemand);
        busy_d    = (state_d != StIdle);
        xferok_d  = (state_q == StDemand) && (state_d == StHold);
        timeout_d = (state_q == StDemand) && (state_d == StRecover);

        if (state_q == StIdle && any_req) begin
            ptr_d   = win_idx;
            grant_d = win_oh;
        end
        if (state_d == StIdle || state_d == StRecover) begin
            grant_d = '0;
        end
        if (state_q == StDemand && state_d == StDemand) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign grant   = grant_q;
    assign demand  = demand_q;
    assign xferOk  = xferok_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

    a_grant_onehot0: assert property (@(posedge masterClk) disable iff (!CROBAR_N)
        $onehot0(grant));
    a_demand_granted: assert property (@(posedge masterClk) disable iff (!CROBAR_N)
        demand |-> (grant != '0));
    a_pulse_exclusive: assert property (@(posedge masterClk) disable iff (!CROBAR_N)
        !(xferOk && timeout));

endmodule

// File: tb/tb_ebus_arb.sv
// Directed bench for ebus_arb (NREQ=4, TMO=4); obs packs
// {grant[3:0], demand, xferOk, timeout, busy}.
module tb_ebus_arb;

    logic       masterClk;
    logic       CROBAR_N;
    logic [3:0] req;
    logic [3:0] done;
    logic       xfer;
    logic [3:0] grant;
    logic       demand;
    logic       xferOk;
    logic       timeout;
    logic       busy;

    logic [7:0] obs;
    logic [7:0] want;
    int         vectors;
    int         miscompares;

    assign obs = {grant, demand, xferOk, timeout, busy};

    ebus_arb #(
        .NREQ(4),
        .TMO (4)
    ) dut (
        .masterClk(masterClk),
        .CROBAR_N (CROBAR_N),
        .req      (req),
        .done     (done),
        .xfer     (xfer),
        .grant    (grant),
        .demand   (demand),
        .xferOk   (xferOk),
        .timeout  (timeout),
        .busy     (busy)
    );

    initial masterClk = 1'b0;
    always #5 masterClk = ~masterClk;

    // Structural invariants checked every cycle while out of reset.
    always @(negedge masterClk) begin
        if (CROBAR_N) begin
            vectors++;
            if (!$onehot0(grant) || (demand && grant == 4'b0) || (xferOk && timeout)) begin
                miscompares++;
                $display("FAIL invariant: grant=%b demand=%b xferOk=%b timeout=%b",
                         grant, demand, xferOk, timeout);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge masterClk);
        #1;
    endtask

    task automatic apply_reset();
        CROBAR_N = 1'b0;
        req      = 4'b0;
        done     = 4'b0;
        xfer     = 1'b0;
        tick();
        CROBAR_N = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        CROBAR_N = 1'b0;
        #1;
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL reset_async: obs=%b want=%b", obs, want);
        end
        req = 4'b1111;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL reset_held: obs=%b want=%b", obs, want);
        end
        CROBAR_N = 1'b1;
        req      = 4'b0;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL reset_idle: obs=%b want=%b", obs, want);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0001;
        tick();
        want = 8'b0001_0001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL single_setup: obs=%b want=%b", obs, want);
        end
        req = 4'b0;
        tick();
        want = 8'b0001_1001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL single_demand: obs=%b want=%b", obs, want);
        end
        tick();
        want = 8'b0001_1001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL single_wait: obs=%b want=%b", obs, want);
        end
        xfer = 1'b1;
        tick();
        want = 8'b0001_0101; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL single_xferok: obs=%b want=%b", obs, want);
        end
        // done with xfer still high must not release
        done = 4'b0001;
        tick();
        want = 8'b0001_0001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL single_hold: obs=%b want=%b", obs, want);
        end
        xfer = 1'b0;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL single_release: obs=%b want=%b", obs, want);
        end
        done = 4'b0;
    endtask

    task automatic test_fairness();
        logic [3:0] oh;
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            oh = 4'(1 << (i % 4));
            tick();
            want = {oh, 4'b0001}; vectors++;
            if (obs !== want) begin
                miscompares++; $display("FAIL fair_setup[%0d]: obs=%b want=%b", i, obs, want);
            end
            tick();
            xfer = 1'b1;
            tick();
            want = {oh, 4'b0101}; vectors++;
            if (obs !== want) begin
                miscompares++; $display("FAIL fair_hold[%0d]: obs=%b want=%b", i, obs, want);
            end
            xfer = 1'b0;
            done = oh;
            tick();
            want = 8'b0000_0000; vectors++;
            if (obs !== want) begin
                miscompares++; $display("FAIL fair_gap[%0d]: obs=%b want=%b", i, obs, want);
            end
            done = 4'b0;
        end
        req = 4'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            want = 8'b0010_0001; vectors++;
            if (obs !== want) begin
                miscompares++; $display("FAIL b2b_setup[%0d]: obs=%b want=%b", i, obs, want);
            end
            tick();
            // releases from requesters that do not own the bus are ignored
            done = 4'b1101;
            tick();
            want = 8'b0010_1001; vectors++;
            if (obs !== want) begin
                miscompares++; $display("FAIL b2b_ignore[%0d]: obs=%b want=%b", i, obs, want);
            end
            done = 4'b0;
            xfer = 1'b1;
            tick();
            xfer = 1'b0;
            done = 4'b0010;
            tick();
            want = 8'b0000_0000; vectors++;
            if (obs !== want) begin
                miscompares++; $display("FAIL b2b_gap[%0d]: obs=%b want=%b", i, obs, want);
            end
            done = 4'b0;
        end
        req = 4'b0;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL b2b_idle: obs=%b want=%b", obs, want);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        req = 4'b0100;
        tick();
        req = 4'b0;
        tick();
        want = 8'b0100_1001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL tmo_demand: obs=%b want=%b", obs, want);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            want = 8'b0100_1001; vectors++;
            if (obs !== want) begin
                miscompares++; $display("FAIL tmo_wait[%0d]: obs=%b want=%b", i, obs, want);
            end
        end
        tick();
        want = 8'b0000_0011; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL tmo_pulse: obs=%b want=%b", obs, want);
        end
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL tmo_idle: obs=%b want=%b", obs, want);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req = 4'b0001;
        tick();
        req = 4'b0;
        repeat (4) tick();
        // cnt is now TMO-1; xfer arrives on the timeout cycle
        xfer = 1'b1;
        tick();
        want = 8'b0001_0101; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL simul_xfer_wins: obs=%b want=%b", obs, want);
        end
        xfer = 1'b0;
        tick();
        want = 8'b0001_0001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL simul_hold: obs=%b want=%b", obs, want);
        end
        done = 4'b0001;
        tick();
        done = 4'b0;
    endtask

    task automatic test_abort();
        apply_reset();
        req = 4'b0010;
        tick();
        req  = 4'b0;
        done = 4'b0010;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL abort_setup: obs=%b want=%b", obs, want);
        end
        done = 4'b0;
        req  = 4'b1001;
        tick();
        want = 8'b1000_0001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL abort_rr: obs=%b want=%b", obs, want);
        end
        req = 4'b0;
        tick();
        done = 4'b1000;
        xfer = 1'b1;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL abort_demand: obs=%b want=%b", obs, want);
        end
        done = 4'b0;
        xfer = 1'b0;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL abort_nopulse: obs=%b want=%b", obs, want);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0100;
        tick();
        req = 4'b0;
        tick();
        xfer = 1'b1;
        tick();
        xfer = 1'b0;
        tick();
        want = 8'b0100_0001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL areset_hold: obs=%b want=%b", obs, want);
        end
        #2;
        CROBAR_N = 1'b0;
        #1;
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL areset_drop: obs=%b want=%b", obs, want);
        end
        tick();
        CROBAR_N = 1'b1;
        tick();
        want = 8'b0000_0000; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL areset_release: obs=%b want=%b", obs, want);
        end
        // a stale pointer of 2 would pick index 3 here
        req = 4'b1001;
        tick();
        want = 8'b0001_0001; vectors++;
        if (obs !== want) begin
            miscompares++; $display("FAIL areset_ptr: obs=%b want=%b", obs, want);
        end
        req  = 4'b0;
        done = 4'b0001;
        tick();
        done = 4'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        CROBAR_N    = 1'b1;
        req         = 4'b0;
        done        = 4'b0;
        xfer        = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_timeout();
        test_simultaneous();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ebus_arb.md
EBUS_ARB -- requirements
Module: ebus_arb

Interface
REQ-001 Parameter NREQ, default 4, number of EBUS master requesters; index 0 = CON, 1 = PI, 2 = DTE, 3 = spare.
REQ-002 Parameter TMO, default 255, demand-phase cycles allowed without xfer before timeout; legal range 1..255.
REQ-003 masterClk  in  1  sole clock, rising edge.
REQ-004 CROBAR_N  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  NREQ  per-requester level request for EBUS mastership.
REQ-006 done  in  NREQ  per-requester release; only the granted bit is honoured.
REQ-007 xfer  in  1  slave transfer acknowledge, level.
REQ-008 grant  out  NREQ  one-hot mastership; drives EBUSdriver.driving select for the winner.
REQ-009 demand  out  1  EBUS demand to slaves.
REQ-010 xferOk  out  1  one-cycle pulse on the first cycle xfer is seen in DEMAND.
REQ-011 timeout  out  1  one-cycle pulse on a demand timeout.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, SETUP, DEMAND, HOLD, RECOVER; exactly one state active.
REQ-014 IDLE: if any req bit is set, the winner is chosen by round-robin; next state SETUP, and grant goes one-hot to the winner on that edge.
REQ-015 Round-robin: search starts at index ptr+1 modulo NREQ and wraps; ptr is set to the winner index at grant.
REQ-016 SETUP lasts exactly 1 cycle with demand=0, giving the driver one cycle of bus settle; next state DEMAND.
REQ-017 DEMAND: demand=1, and a TMO-width-sized counter cnt starts at 0 and increments each cycle.
REQ-018 DEMAND with xfer=1: xferOk pulses and next state is HOLD, with demand=0 registered on that same edge.
REQ-019 DEMAND with xfer=0 and cnt==TMO-1: timeout pulses and next state is RECOVER; grant is cleared and demand=0.
REQ-020 If xfer and the timeout condition occur in the same cycle, xfer wins: xferOk fires and timeout does not.
REQ-021 HOLD: grant is held until done[winner]=1 and xfer=0; then grant clears and next state is IDLE.
REQ-022 done[winner] in SETUP or DEMAND aborts the transaction: grant=0, demand=0, next state IDLE, no xferOk and no timeout.
REQ-023 RECOVER lasts exactly 1 cycle with all outputs 0 except busy; next state IDLE.
REQ-024 done bits of non-granted requesters and req changes during a transaction are ignored; a still-asserted req is arbitrated on the next IDLE.
REQ-025 Minimum gap between successive grants is 1 IDLE cycle; the same requester may win back-to-back only if no other req bit is set.
REQ-026 Invariants: grant is zero or one-hot; demand implies grant is non-zero; xferOk and timeout are never high in the same cycle.
REQ-027 All outputs are registered, with no combinational path from any input to any output.

Reset
REQ-028 CROBAR_N=0 forces state IDLE, grant=0, demand=0, xferOk=0, timeout=0, busy=0, cnt=0, ptr=NREQ-1 (first search starts at index 0), asynchronously and without waiting for a clock edge.
REQ-029 Reset asserted mid-transaction drops grant and demand immediately; no pulse is emitted on reset release.
REQ-030 First arbitration occurs on the first rising edge after CROBAR_N deasserts.

Verification
REQ-031 Single request: req=0001 -> grant=0001 at edge 1, demand=1 at edge 2; xfer at cycle 5 -> xferOk pulse, demand=0; done[0] with xfer=0 -> grant=0, busy=0 next edge.
REQ-032 Fairness: req=1111 held, each requester completes immediately -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 Timeout with TMO=4: grant requester 2, xfer held 0 -> timeout pulse exactly 4 cycles after demand rises, then RECOVER 1 cycle, then IDLE.
REQ-034 Simultaneous: xfer rises in the same cycle cnt==TMO-1 -> xferOk=1, timeout=0, state HOLD.
REQ-035 Abort and reset: done[winner] in DEMAND -> IDLE with no pulses; a separate run pulses CROBAR_N low in HOLD -> all outputs 0 asynchronously and next grant goes to index 0.
